// File: rtl/sr_mc_control_pkg.sv
// Shared constants for the schoolRISCV multicycle control: RV32 opcode/funct
// fields, ALU operation codes, FSM state encodings and instruction classes.
package sr_mc_control_pkg;

    // opcode field
    localparam logic [6:0] RVOP_ADDI = 7'b0010011;  // I-type ALU group
    localparam logic [6:0] RVOP_ADD  = 7'b0110011;  // R-type ALU group
    localparam logic [6:0] RVOP_LUI  = 7'b0110111;
    localparam logic [6:0] RVOP_BEQ  = 7'b1100011;  // conditional branch group

    // funct3 field
    localparam logic [2:0] RVF3_ADD  = 3'b000;
    localparam logic [2:0] RVF3_SLL  = 3'b001;
    localparam logic [2:0] RVF3_SLTU = 3'b011;
    localparam logic [2:0] RVF3_XOR  = 3'b100;
    localparam logic [2:0] RVF3_SRL  = 3'b101;
    localparam logic [2:0] RVF3_OR   = 3'b110;
    localparam logic [2:0] RVF3_AND  = 3'b111;
    localparam logic [2:0] RVF3_BEQ  = 3'b000;
    localparam logic [2:0] RVF3_BNE  = 3'b001;

    // funct7 field
    localparam logic [6:0] RVF7_ZERO = 7'b0000000;
    localparam logic [6:0] RVF7_SUB  = 7'b0100000;

    // ALU operation codes; ADD is zero so an idle datapath reads as all-zero
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_SRL  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_SUB  = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;

    // control FSM states
    typedef enum logic [2:0] {
        MCS_BOOT   = 3'd0,
        MCS_FETCH  = 3'd1,
        MCS_DECODE = 3'd2,
        MCS_EXEC   = 3'd3,
        MCS_WB     = 3'd4,
        MCS_BRANCH = 3'd5,
        MCS_HALT   = 3'd6
    } mc_state_e;

    // decoded instruction class
    typedef enum logic [2:0] {
        CLS_ALU_R   = 3'd0,
        CLS_ALU_I   = 3'd1,
        CLS_LUI     = 3'd2,
        CLS_BR_EQ   = 3'd3,
        CLS_BR_NE   = 3'd4,
        CLS_ILLEGAL = 3'd5
    } ins_class_e;

    // true for classes that go through the EXEC/WB path
    function automatic logic is_alu_class(input ins_class_e cls);
        return (cls == CLS_ALU_R) || (cls == CLS_ALU_I);
    endfunction

endpackage

// File: rtl/sr_mc_control_decode.sv
// Combinational instruction decoder for the multicycle control. Classifies the
// IR fields and selects the ALU operation and operand source. Nothing here is
// registered: the IR keeps the fields stable for the whole instruction.
module sr_mc_control_decode
    import sr_mc_control_pkg::*;
(
    input  logic [6:0] cmd_op,
    input  logic [2:0] cmd_f3,
    input  logic [6:0] cmd_f7,
    output ins_class_e cls,
    output logic [3:0] alu_ctl,
    output logic       alu_src
);

    // classify the instruction; anything not explicitly matched is illegal
    always_comb begin
        cls     = CLS_ILLEGAL;
        alu_ctl = ALU_ADD;
        alu_src = 1'b0;
        case (cmd_op)
            RVOP_ADD: begin
                if (cmd_f7 == RVF7_ZERO) begin
                    cls = CLS_ALU_R;
                    case (cmd_f3)
                        RVF3_ADD:  alu_ctl = ALU_ADD;
                        RVF3_SLL:  alu_ctl = ALU_SLL;
                        RVF3_SLTU: alu_ctl = ALU_SLTU;
                        RVF3_XOR:  alu_ctl = ALU_XOR;
                        RVF3_SRL:  alu_ctl = ALU_SRL;
                        RVF3_OR:   alu_ctl = ALU_OR;
                        RVF3_AND:  alu_ctl = ALU_AND;
                        default:   cls     = CLS_ILLEGAL;  // SLT
                    endcase
                end else if (cmd_f7 == RVF7_SUB && cmd_f3 == RVF3_ADD) begin
                    cls     = CLS_ALU_R;
                    alu_ctl = ALU_SUB;
                end
            end
            RVOP_ADDI: begin
                alu_src = 1'b1;
                cls     = CLS_ALU_I;
                case (cmd_f3)
                    RVF3_ADD: alu_ctl = ALU_ADD;
                    RVF3_AND: alu_ctl = ALU_AND;
                    RVF3_OR:  alu_ctl = ALU_OR;
                    RVF3_XOR: alu_ctl = ALU_XOR;
                    // shift-immediates carry funct7 in imm[11:5]; SRAI etc. not supported
                    RVF3_SLL: begin
                        alu_ctl = ALU_SLL;
                        if (cmd_f7 != RVF7_ZERO) cls = CLS_ILLEGAL;
                    end
                    RVF3_SRL: begin
                        alu_ctl = ALU_SRL;
                        if (cmd_f7 != RVF7_ZERO) cls = CLS_ILLEGAL;
                    end
                    default: cls = CLS_ILLEGAL;  // SLTI/SLTIU
                endcase
            end
            RVOP_LUI: cls = CLS_LUI;
            RVOP_BEQ: begin
                alu_ctl = ALU_SUB;
                case (cmd_f3)
                    RVF3_BEQ: cls = CLS_BR_EQ;
                    RVF3_BNE: cls = CLS_BR_NE;
                    default:  cls = CLS_ILLEGAL;
                endcase
            end
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/sr_mc_control.sv
// Multicycle control FSM for the schoolRISCV datapath: fetch with a req/ack
// memory handshake, decode, execute, writeback and branch resolution. Also
// keeps a retired-instruction counter and a sticky illegal-instruction halt.
module sr_mc_control
    import sr_mc_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       cmdOp,
    input  logic [2:0]       cmdF3,
    input  logic [6:0]       cmdF7,
    input  logic             aluZero,
    input  logic             imAck,
    output logic             imReq,
    output logic             irWrite,
    output logic             pcWrite,
    output logic             pcSrc,
    output logic             regWrite,
    output logic             aluSrc,
    output logic             wdSrc,
    output logic [3:0]       aluControl,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    mc_state_e        state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    ins_class_e cls;
    logic [3:0] dec_alu_ctl;
    logic       dec_alu_src;

    sr_mc_control_decode u_decode (
        .cmd_op  (cmdOp),
        .cmd_f3  (cmdF3),
        .cmd_f7  (cmdF7),
        .cls     (cls),
        .alu_ctl (dec_alu_ctl),
        .alu_src (dec_alu_src)
    );

    // next-state: fetch waits on imAck, decode dispatches by class, HALT is terminal
    always_comb begin
        state_d = state_q;
        case (state_q)
            MCS_BOOT:   state_d = MCS_FETCH;
            MCS_FETCH:  if (imAck) state_d = MCS_DECODE;
            MCS_DECODE: begin
                if (is_alu_class(cls))                          state_d = MCS_EXEC;
                else if (cls == CLS_LUI)                        state_d = MCS_WB;
                else if (cls == CLS_BR_EQ || cls == CLS_BR_NE)  state_d = MCS_BRANCH;
                else                                            state_d = MCS_HALT;
            end
            MCS_EXEC:   state_d = MCS_WB;
            MCS_WB:     state_d = MCS_FETCH;
            MCS_BRANCH: state_d = MCS_FETCH;
            MCS_HALT:   state_d = MCS_HALT;
            default:    state_d = MCS_BOOT;
        endcase
    end

    // datapath controls decoded from the current state and the IR fields
    always_comb begin
        imReq      = 1'b0;
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        pcSrc      = 1'b0;
        regWrite   = 1'b0;
        aluSrc     = 1'b0;
        wdSrc      = 1'b0;
        aluControl = ALU_ADD;
        case (state_q)
            MCS_FETCH: begin
                imReq   = 1'b1;
                irWrite = imAck;
            end
            MCS_EXEC: begin
                aluSrc     = dec_alu_src;
                aluControl = dec_alu_ctl;
            end
            MCS_WB: begin
                // ALU inputs stay as in EXEC so the result is still valid at the write
                regWrite   = 1'b1;
                pcWrite    = 1'b1;
                aluSrc     = dec_alu_src;
                aluControl = dec_alu_ctl;
                wdSrc      = (cls == CLS_LUI);
            end
            MCS_BRANCH: begin
                // rs1 - rs2 compare; the zero flag picks the branch target
                aluControl = ALU_SUB;
                pcWrite    = 1'b1;
                pcSrc      = (cls == CLS_BR_EQ) ? aluZero : ~aluZero;
            end
            default: ;
        endcase
    end

    // sticky illegal flag is set on the DECODE->HALT transition; count every PC update
    always_comb begin
        illegal_d = illegal_q | ((state_q == MCS_DECODE) && (cls == CLS_ILLEGAL));
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, pcWrite};
    end

    // state, halt flag and retire counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MCS_BOOT;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_sr_mc_control.sv
// Scoreboard bench for sr_mc_control: each driven cycle pushes the expected
// control vector and retire count; the negedge monitor pops and compares.
module tb_sr_mc_control;

    localparam logic [3:0] A_ADD = 4'd0, A_OR = 4'd1, A_SRL = 4'd2, A_SLTU = 4'd3,
                           A_SUB = 4'd4, A_AND = 4'd5, A_XOR = 4'd6, A_SLL = 4'd7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] cmdOp;
    logic [2:0] cmdF3;
    logic [6:0] cmdF7;
    logic       aluZero;
    logic       imAck;

    logic        imReq, irWrite, pcWrite, pcSrc, regWrite, aluSrc, wdSrc, illegal;
    logic [3:0]  aluControl;
    logic [31:0] retired;
    logic        imReq4, irWrite4, pcWrite4, pcSrc4, regWrite4, aluSrc4, wdSrc4, illegal4;
    logic [3:0]  aluControl4;
    logic [3:0]  retired4;

    always #5 clk = ~clk;

    sr_mc_control u_dut (
        .clk(clk), .rst_n(rst_n), .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
        .aluZero(aluZero), .imAck(imAck), .imReq(imReq), .irWrite(irWrite),
        .pcWrite(pcWrite), .pcSrc(pcSrc), .regWrite(regWrite), .aluSrc(aluSrc),
        .wdSrc(wdSrc), .aluControl(aluControl), .illegal(illegal), .retired(retired)
    );

    sr_mc_control #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
        .aluZero(aluZero), .imAck(imAck), .imReq(imReq4), .irWrite(irWrite4),
        .pcWrite(pcWrite4), .pcSrc(pcSrc4), .regWrite(regWrite4), .aluSrc(aluSrc4),
        .wdSrc(wdSrc4), .aluControl(aluControl4), .illegal(illegal4), .retired(retired4)
    );

    wire [11:0] vec  = {imReq, irWrite, pcWrite, pcSrc, regWrite, aluSrc, wdSrc, aluControl, illegal};
    wire [11:0] vec4 = {imReq4, irWrite4, pcWrite4, pcSrc4, regWrite4, aluSrc4, wdSrc4, aluControl4, illegal4};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    typedef struct {
        string       tag;
        logic [11:0] sig;
        int unsigned ret;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int unsigned exp_ret = 0;

    // bit order: imReq irWrite pcWrite pcSrc regWrite aluSrc wdSrc aluControl[3:0] illegal
    function automatic logic [11:0] mk(input logic req, input logic irw, input logic pcw,
                                       input logic pcs, input logic rw, input logic as,
                                       input logic wd, input logic [3:0] ac, input logic ill);
        return {req, irw, pcw, pcs, rw, as, wd, ac, ill};
    endfunction

    // monitor: compare mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, "_ctl"},  {20'd0, vec},  {20'd0, e.sig});
            chk({e.tag, "_ctl4"}, {20'd0, vec4}, {20'd0, e.sig});
            chk({e.tag, "_ret"},  retired, e.ret);
            chk({e.tag, "_ret4"}, {28'd0, retired4}, e.ret % 16);
        end
    end

    // one clock cycle: drive inputs, record expectation, advance past the edge
    task automatic cyc(input string tag, input logic ack, input logic z, input logic [11:0] sig);
        imAck   = ack;
        aluZero = z;
        sb.push_back('{tag, sig, exp_ret});
        @(posedge clk);
        #1;
        if (sig[9]) exp_ret++;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        cmdOp = op; cmdF3 = f3; cmdF7 = f7;
    endtask

    task automatic do_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [3:0] ac, input logic as,
                          input int waits);
        set_ir(op, f3, f7);
        for (int i = 0; i < waits; i++) cyc({tag, "_wait"}, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,A_ADD,0));
        cyc({tag, "_fetch"}, 1'b1, 1'b0, mk(1,1,0,0,0,0,0,A_ADD,0));
        cyc({tag, "_dec"},   1'b1, 1'b0, mk(0,0,0,0,0,0,0,A_ADD,0));
        cyc({tag, "_exec"},  1'b1, 1'b0, mk(0,0,0,0,0,as,0,ac,0));
        cyc({tag, "_wb"},    1'b1, 1'b0, mk(0,0,1,0,1,as,0,ac,0));
    endtask

    task automatic do_lui(input string tag);
        set_ir(7'b0110111, 3'($urandom_range(7)), 7'($urandom_range(127)));
        cyc({tag, "_fetch"}, 1'b1, 1'b0, mk(1,1,0,0,0,0,0,A_ADD,0));
        cyc({tag, "_dec"},   1'b1, 1'b0, mk(0,0,0,0,0,0,0,A_ADD,0));
        cyc({tag, "_wb"},    1'b1, 1'b0, mk(0,0,1,0,1,0,1,A_ADD,0));
    endtask

    task automatic do_br(input string tag, input logic [2:0] f3, input logic z, input logic pcs);
        set_ir(7'b1100011, f3, 7'd0);
        cyc({tag, "_fetch"}, 1'b1, z, mk(1,1,0,0,0,0,0,A_ADD,0));
        cyc({tag, "_dec"},   1'b1, z, mk(0,0,0,0,0,0,0,A_ADD,0));
        cyc({tag, "_br"},    1'b1, z, mk(0,0,1,pcs,0,0,0,A_SUB,0));
    endtask

    task automatic do_illegal(input string tag, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input int n);
        set_ir(op, f3, f7);
        cyc({tag, "_fetch"}, 1'b1, 1'b0, mk(1,1,0,0,0,0,0,A_ADD,0));
        cyc({tag, "_dec"},   1'b1, 1'b0, mk(0,0,0,0,0,0,0,A_ADD,0));
        for (int i = 0; i < n; i++) cyc({tag, "_halt"}, 1'b1, 1'b1, mk(0,0,0,0,0,0,0,A_ADD,1));
    endtask

    task automatic do_reset(input string tag);
        rst_n   = 1'b0;
        exp_ret = 0;
        cyc({tag, "_rst"}, 1'b1, 1'b0, 12'd0);
        cyc({tag, "_rst"}, 1'b1, 1'b0, 12'd0);
        rst_n = 1'b1;
        cyc({tag, "_boot"}, 1'b1, 1'b0, 12'd0);
    endtask

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] ac;
        logic       as;
    } alu_vec_t;

    alu_vec_t tbl [13] = '{
        '{"sub",  7'b0110011, 3'b000, 7'b0100000, A_SUB,  1'b0},
        '{"or",   7'b0110011, 3'b110, 7'b0000000, A_OR,   1'b0},
        '{"and",  7'b0110011, 3'b111, 7'b0000000, A_AND,  1'b0},
        '{"xor",  7'b0110011, 3'b100, 7'b0000000, A_XOR,  1'b0},
        '{"sll",  7'b0110011, 3'b001, 7'b0000000, A_SLL,  1'b0},
        '{"srl",  7'b0110011, 3'b101, 7'b0000000, A_SRL,  1'b0},
        '{"sltu", 7'b0110011, 3'b011, 7'b0000000, A_SLTU, 1'b0},
        '{"andi", 7'b0010011, 3'b111, 7'b1010101, A_AND,  1'b1},
        '{"ori",  7'b0010011, 3'b110, 7'b0000001, A_OR,   1'b1},
        '{"xori", 7'b0010011, 3'b100, 7'b1111111, A_XOR,  1'b1},
        '{"slli", 7'b0010011, 3'b001, 7'b0000000, A_SLL,  1'b1},
        '{"srli", 7'b0010011, 3'b101, 7'b0000000, A_SRL,  1'b1},
        '{"addi", 7'b0010011, 3'b000, 7'b0000000, A_ADD,  1'b1}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; imAck = 1'b1; aluZero = 1'b0;
        set_ir(7'd0, 3'd0, 7'd0);
        @(posedge clk);
        #1;

        // reset with imAck held high, then boot and a zero-wait ADD
        do_reset("init");
        do_alu("add", 7'b0110011, 3'b000, 7'b0000000, A_ADD, 1'b0, 0);

        // ADDI behind a 3-cycle memory wait
        do_alu("addi_w3", 7'b0010011, 3'b000, 7'b0000000, A_ADD, 1'b1, 3);

        // remaining ALU ops, mixed memory latency
        foreach (tbl[i]) do_alu(tbl[i].name, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].ac, tbl[i].as, i % 3);

        // branches: BEQ follows aluZero, BNE inverts it
        do_br("beq_z1", 3'b000, 1'b1, 1'b1);
        do_br("beq_z0", 3'b000, 1'b0, 1'b0);
        do_br("bne_z1", 3'b001, 1'b1, 1'b0);
        do_br("bne_z0", 3'b001, 1'b0, 1'b1);

        // 16 LUIs push the 4-bit counter through a wrap
        for (int i = 0; i < 16; i++) do_lui("lui");

        // reset asserted in the WB cycle of an ADD
        set_ir(7'b0110011, 3'b000, 7'b0000000);
        cyc("rwb_fetch", 1'b1, 1'b0, mk(1,1,0,0,0,0,0,A_ADD,0));
        cyc("rwb_dec",   1'b1, 1'b0, mk(0,0,0,0,0,0,0,A_ADD,0));
        cyc("rwb_exec",  1'b1, 1'b0, mk(0,0,0,0,0,0,0,A_ADD,0));
        chk("rwb_regwrite_before", {31'd0, regWrite}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rwb_regwrite_after", {31'd0, regWrite}, 32'd0);
        chk("rwb_pcwrite_after",  {31'd0, pcWrite},  32'd0);
        @(posedge clk);
        #1;
        exp_ret = 0;
        cyc("rwb_rst", 1'b1, 1'b0, 12'd0);
        rst_n = 1'b1;
        cyc("rwb_boot", 1'b1, 1'b0, 12'd0);
        do_lui("after_rst");

        // illegal: load opcode halts, imReq stays low for 20 cycles
        do_illegal("load", 7'b0000011, 3'b010, 7'd0, 20);
        do_reset("r2");
        do_illegal("blt", 7'b1100011, 3'b100, 7'd0, 5);
        do_reset("r3");
        do_alu("ori2", 7'b0010011, 3'b110, 7'd0, A_OR, 1'b1, 1);
        do_illegal("slli_f7", 7'b0010011, 3'b001, 7'b0100000, 5);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sr_mc_control.md
Name: sr_mc_control

Overview:
- Multicycle control FSM for the schoolRISCV datapath.
- Sequences instruction fetch through an instruction-memory req/ack handshake, then decode, execute, writeback and branch resolution.
- Issues one-cycle enables to the PC, the instruction register (IR) and the register file.
- Sits in sr_cpu between the IR/ALU datapath and the instruction memory. Also keeps a retired-instruction counter and a sticky illegal-instruction halt.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmdOp  input  7  opcode field from IR
cmdF3  input  3  funct3 field from IR
cmdF7  input  7  funct7 field from IR
aluZero  input  1  ALU result-is-zero flag
imAck  input  1  instruction memory data valid for current request
imReq  output  1  instruction fetch request
irWrite  output  1  load IR from memory data
pcWrite  output  1  update PC this cycle
pcSrc  output  1  1 = PC+imm, 0 = PC+4 (valid when pcWrite=1)
regWrite  output  1  register file write enable
aluSrc  output  1  0 = rs2, 1 = immediate
wdSrc  output  1  0 = ALU result, 1 = U-immediate
aluControl  output  4  ALU operation code (ALU_* encodings)
illegal  output  1  sticky illegal-instruction flag
retired  output  CNT_W  count of retired instructions

Behaviour:
- Reset: clk and rst_n as above; asynchronous active-low.
  - While rst_n=0: state=BOOT, all outputs 0, retired=0, illegal=0.
  - Reset mid-instruction aborts it; no partial write survives.
- States and transitions: BOOT, FETCH, DECODE, EXEC, WB, BRANCH, HALT.
  - BOOT -> FETCH unconditionally after one cycle.
  - FETCH: imReq=1. While imAck=0, hold (unbounded wait). On imAck=1: irWrite=1 in the same cycle, -> DECODE.
  - DECODE (IR valid):
    - R-type or I-ALU class -> EXEC.
    - LUI -> WB.
    - BEQ/BNE -> BRANCH.
    - Anything else -> HALT.
  - EXEC: aluSrc and aluControl driven per instruction, no enables -> WB.
  - WB: regWrite=1, pcWrite=1, pcSrc=0. aluSrc/aluControl held from EXEC. wdSrc=1 for LUI -> FETCH.
  - BRANCH: aluControl=ALU_SUB, aluSrc=0, pcWrite=1.
    - BEQ: pcSrc=aluZero.
    - BNE: pcSrc=~aluZero.
    - -> FETCH.
  - HALT: terminal until reset. illegal=1, imReq=0, all enables 0.
- Supported instructions:
  - R-type: ADD, SUB, OR, AND, XOR, SLL, SRL, SLTU.
  - I-type: ADDI, ANDI, ORI, XORI, SLLI, SRLI.
  - LUI, BEQ, BNE.
  - Branch funct3 other than BEQ/BNE is illegal. SLLI/SRLI with nonzero funct7 is illegal.
- Latency with zero-wait memory (imAck high in the first FETCH cycle):
  - ALU ops: 4 cycles.
  - LUI: 3 cycles.
  - Branch: 3 cycles.
  - Each memory wait cycle adds 1.
- Output timing:
  - Enables (irWrite, pcWrite, regWrite) are single-cycle pulses; never asserted outside their state.
  - aluControl defaults to ALU_ADD and aluSrc/wdSrc default to 0 in states not listed.
  - imReq is a Moore output of state FETCH only.
- Retire counter:
  - retired increments by 1 on every cycle with pcWrite=1 (WB or BRANCH).
  - Wraps modulo 2^CNT_W with no flag.
  - Not incremented on entry to HALT.
- imAck outside FETCH is ignored.
- All outputs are combinational from state and registered IR fields, except retired and illegal, which are registered.

Decomposition:
- Shared header sr_cpu.vh:
  - RVOP_*/RVF3_*/RVF7_* opcode constants (existing).
  - ALU_* codes (existing).
  - New state encodings MCS_BOOT..MCS_HALT, 3-bit.
- Sub-module sr_mc_decode: purely combinational.
  - Inputs: cmdOp/F3/F7.
  - Outputs: instruction class (ALU_R, ALU_I, LUI, BR_EQ, BR_NE, ILLEGAL), aluControl, aluSrc.
  - The FSM registers nothing from it; IR holds fields stable.

Test Plan:
- Reset, then release with imAck tied 1:
  - BOOT for 1 cycle, then imReq=1.
  - irWrite pulses in FETCH.
  - Outputs 0 and retired=0 during reset.
- ADD x3,x1,x2 with imAck=1:
  - States FETCH, DECODE, EXEC, WB.
  - In WB: regWrite=1, pcWrite=1, pcSrc=0, aluControl=ALU_ADD.
  - retired 0->1.
- ADDI with imAck delayed 3 cycles:
  - imReq high for 4 cycles, irWrite only in the 4th.
  - Total 7 cycles to the next FETCH.
  - aluSrc=1 in EXEC and WB.
- BEQ:
  - With aluZero=1: BRANCH pcWrite=1, pcSrc=1.
  - Repeat with aluZero=0: pcSrc=0.
  - BNE inverted for both cases.
  - regWrite stays 0.
- Illegal cases:
  - Opcode 7'b0000011 (load): DECODE -> HALT, illegal=1, imReq stays 0 for 20 cycles, retired unchanged.
  - Branch with funct3=3'b100 (BLT): also HALT.
- Assert rst_n=0 in WB of an ADD:
  - regWrite drops immediately.
  - retired not incremented.
  - Restart from BOOT.
- With CNT_W=4, retire 16 LUI instructions: retired wraps to 0.
